// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM states, byte type and
// the link header length.
package uart_pkg;

    typedef logic [7:0] byte_t;

    // checksum, address and count precede the data bytes on the link
    localparam int HDR_BYTES = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SUM       = 3'd1,
        SEND_CK   = 3'd2,
        SEND_ADDR = 3'd3,
        SEND_CNT  = 3'd4,
        SEND_DATA = 3'd5,
        SETTLE    = 3'd6,
        DONE      = 3'd7
    } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping at N, returned one-hot.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte transmitter between N requesters; frames each packet as
// checksum | address | count | data and serves requesters round-robin.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = 8
) (
    input  logic            clk,
    input  logic            RESET,
    input  logic [N-1:0]    req,
    input  logic [8*N-1:0]  req_addr,
    input  logic [8*N-1:0]  req_count,
    output logic [IDXW-1:0] rd_idx,
    input  logic [8*N-1:0]  rd_data,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic [7:0]      tx_data,
    output logic            tx_start,
    input  logic            tx_busy,
    output logic [2:0]      dbg_state
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_t          state_q, state_d;
    state_t          ret_q, ret_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    done_q, done_d;
    logic            tx_start_q, tx_start_d;
    byte_t           tx_data_q, tx_data_d;
    logic [IDXW-1:0] rd_idx_q, rd_idx_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    byte_t           sum_q, sum_d;
    byte_t           addr_q, addr_d;
    byte_t           cnt_q, cnt_d;
    logic            phase_q, phase_d;
    logic            last_q, last_d;

    logic [N-1:0]    arb_gnt;
    logic [PW-1:0]   arb_idx;
    byte_t           sel_addr, sel_cnt, rd_sel;
    logic            at_last;

    rr_arbiter #(.N(N), .PW(PW)) u_rr (
        .req (req),
        .ptr (rr_q),
        .gnt (arb_gnt)
    );

    always_comb begin
        arb_idx  = '0;
        sel_addr = '0;
        sel_cnt  = '0;
        rd_sel   = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_gnt[i]) arb_idx = PW'(i);
        end
        for (int i = 0; i < N; i++) begin
            if (arb_idx == PW'(i)) begin
                sel_addr = req_addr[8*i +: 8];
                sel_cnt  = req_count[8*i +: 8];
            end
            if (gidx_q == PW'(i)) rd_sel = rd_data[8*i +: 8];
        end
    end

    assign at_last = (rd_idx_q == IDXW'(cnt_q));

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q    <= IDLE;
            ret_q      <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            rd_idx_q   <= '0;
            rr_q       <= '0;
            gidx_q     <= '0;
            sum_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            rd_idx_q   <= rd_idx_d;
            rr_q       <= rr_d;
            gidx_q     <= gidx_d;
            sum_q      <= sum_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            last_q     <= last_d;
        end
    end

    // Transmitter handshake: tx_start is a one-cycle strobe with tx_data valid
    // in the same cycle; tx_busy is ignored during the SETTLE cycle that
    // follows and must read low before the next strobe is issued.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        rd_idx_d   = rd_idx_q;
        rr_d       = rr_q;
        gidx_d     = gidx_q;
        sum_d      = sum_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        last_d     = last_q;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d    = arb_gnt;
                    gidx_d   = arb_idx;
                    addr_d   = sel_addr;
                    cnt_d    = sel_cnt;
                    sum_d    = sel_addr + sel_cnt;
                    rd_idx_d = '0;
                    rr_d     = (arb_idx == PW'(N - 1)) ? '0 : arb_idx + PW'(1);
                    phase_d  = 1'b0;
                    last_d   = 1'b0;
                    state_d  = SUM;
                end
            end

            // phase_q marks that rd_data holds the byte addressed last cycle
            SUM: begin
                if (phase_q) sum_d = sum_q + rd_sel;
                phase_d = 1'b1;
                if (!last_q) begin
                    if (at_last) last_d = 1'b1;
                    else         rd_idx_d = rd_idx_q + IDXW'(1);
                end else begin
                    rd_idx_d = '0;
                    last_d   = 1'b0;
                    phase_d  = 1'b0;
                    state_d  = SEND_CK;
                end
            end

            SEND_CK: begin
                tx_start_d = 1'b1;
                tx_data_d  = 8'd0 - sum_q;
                ret_d      = SEND_ADDR;
                state_d    = SETTLE;
            end

            SEND_ADDR: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = addr_q;
                    ret_d      = SEND_CNT;
                    state_d    = SETTLE;
                end
            end

            SEND_CNT: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = cnt_q;
                    phase_d    = 1'b0;
                    ret_d      = SEND_DATA;
                    state_d    = SETTLE;
                end
            end

            // last_q: final byte already started, only the drain remains
            SEND_DATA: begin
                if (last_q) begin
                    if (!tx_busy) begin
                        done_d  = gnt_q;
                        state_d = DONE;
                    end
                end else if (!phase_q) begin
                    if (!tx_busy) phase_d = 1'b1;
                end else begin
                    tx_start_d = 1'b1;
                    tx_data_d  = rd_sel;
                    phase_d    = 1'b0;
                    if (at_last) last_d = 1'b1;
                    else         rd_idx_d = rd_idx_q + IDXW'(1);
                    ret_d      = SEND_DATA;
                    state_d    = SETTLE;
                end
            end

            SETTLE: begin
                state_d = ret_q;
            end

            DONE: begin
                gnt_d    = '0;
                last_d   = 1'b0;
                rd_idx_d = '0;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign rd_idx    = rd_idx_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte transmitter and buffer models, a scoreboard
// of expected {requester, byte} pairs and expected done pulses.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N    = 4;
    localparam int IDXW = 8;

    logic            clk = 1'b0;
    logic            RESET;
    logic [N-1:0]    req;
    logic [8*N-1:0]  req_addr;
    logic [8*N-1:0]  req_count;
    logic [IDXW-1:0] rd_idx;
    logic [8*N-1:0]  rd_data;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            tx_busy;
    logic [2:0]      dbg_state;

    uart_tx_arbiter #(.N(N), .IDXW(IDXW)) dut (
        .clk       (clk),
        .RESET     (RESET),
        .req       (req),
        .req_addr  (req_addr),
        .req_count (req_count),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .gnt       (gnt),
        .done      (done),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    // requester buffers and transmitter model
    logic [7:0] mem [N][256];
    logic [7:0] p_addr [N];
    logic [7:0] p_cnt  [N];
    int         busy_cnt = 0;
    int         busy_len = 6;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[8*i +: 8]  = p_addr[i];
            req_count[8*i +: 8] = p_cnt[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) rd_data[8*i +: 8] <= mem[i][rd_idx];
        if (tx_start)          busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    assign tx_busy = (busy_cnt != 0);

    // scoreboard
    int         checks   = 0;
    int         failures = 0;
    logic [11:0] exp_q[$];
    int          exp_done[$];
    logic [7:0]  pkt_sum = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h req=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(negedge clk) begin
        logic [11:0] e;
        int          de;
        if (RESET) begin
            pkt_sum = 8'd0;
        end else begin
            if (tx_start) begin
                chk("start_while_busy", 32'(tx_busy), 32'd0);
                chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_byte act=unexpected 0x%0h req=none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", {4'(oh_idx(gnt)), tx_data}, 32'(e));
                end
                pkt_sum = pkt_sum + tx_data;
            end
            if (|done) begin
                chk("done_vs_start", 32'(tx_start), 32'd0);
                chk("done_eq_gnt", 32'(done), 32'(gnt));
                if (exp_done.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done act=unexpected 0x%0h req=none", done);
                end else begin
                    de = exp_done.pop_front();
                    chk("done_idx", 32'(oh_idx(done)), 32'(de));
                end
                chk("pkt_sum", 32'(pkt_sum), 32'd0);
                pkt_sum = 8'd0;
            end
        end
    end

    // driver tasks
    task automatic setup_pkt(input int i, input logic [7:0] a, input logic [7:0] c);
        p_addr[i] = a;
        p_cnt[i]  = c;
    endtask

    task automatic push_pkt(input int i, input logic [7:0] ck);
        exp_q.push_back({4'(i), ck});
        exp_q.push_back({4'(i), p_addr[i]});
        exp_q.push_back({4'(i), p_cnt[i]});
        for (int j = 0; j <= int'(p_cnt[i]); j++) exp_q.push_back({4'(i), mem[i][j]});
        exp_done.push_back(i);
    endtask

    function automatic logic [7:0] model_ck(input int i);
        logic [7:0] s = p_addr[i] + p_cnt[i];
        for (int j = 0; j <= int'(p_cnt[i]); j++) s = s + mem[i][j];
        return 8'd0 - s;
    endfunction

    task automatic wait_done(input int n, input int budget);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (|done) begin
                seen++;
                req = req & ~done;
            end
        end
        chk("wait_done", 32'(seen), 32'(n));
    endtask

    // stimulus
    initial begin
        int found;
        RESET = 1'b1;
        req   = '0;
        for (int i = 0; i < N; i++) begin
            p_addr[i] = 8'd0;
            p_cnt[i]  = 8'd0;
            for (int j = 0; j < 256; j++) mem[i][j] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_rd_idx", 32'(rd_idx), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        RESET = 1'b0;

        // single requester 0, count 0
        mem[0][0] = 8'h05;
        setup_pkt(0, 8'h10, 8'h00);
        push_pkt(0, 8'hEB);
        @(posedge clk); #1;
        req = 4'b0001;
        wait_done(1, 500);

        // requester 2, count 2
        mem[2][0] = 8'h01; mem[2][1] = 8'h02; mem[2][2] = 8'h03;
        setup_pkt(2, 8'hFF, 8'h02);
        push_pkt(2, 8'hF9);
        req = 4'b0100;
        wait_done(1, 500);

        // requester 3 drops req during the packet
        mem[3][0] = 8'h10; mem[3][1] = 8'h20;
        setup_pkt(3, 8'h5A, 8'h01);
        push_pkt(3, 8'h75);
        req = 4'b1000;
        repeat (3) @(negedge clk);
        req = 4'b0000;
        wait_done(1, 500);

        // all four requesting: rotation 0,1,2,3 then 0 again
        for (int i = 0; i < N; i++) begin
            mem[i][0] = 8'h40 + 8'(i);
            setup_pkt(i, 8'h20 + 8'(i), 8'h00);
        end
        push_pkt(0, 8'hA0);
        push_pkt(1, 8'h9E);
        push_pkt(2, 8'h9C);
        push_pkt(3, 8'h9A);
        req = 4'b1111;
        wait_done(4, 2000);
        push_pkt(0, 8'hA0);
        req = 4'b0001;
        wait_done(1, 500);

        // slow transmitter
        busy_len = 100;
        mem[1][0] = 8'h01; mem[1][1] = 8'hFE;
        setup_pkt(1, 8'h77, 8'h01);
        push_pkt(1, 8'h89);
        req = 4'b0010;
        wait_done(1, 1500);
        busy_len = 6;

        // count 255, data = index
        for (int j = 0; j < 256; j++) mem[2][j] = 8'(j);
        setup_pkt(2, 8'hA5, 8'hFF);
        push_pkt(2, model_ck(2));
        req = 4'b0100;
        wait_done(1, 5000);

        // reset in the middle of SEND_DATA on requester 3
        for (int j = 0; j < 256; j++) mem[3][j] = 8'(255 - j);
        setup_pkt(3, 8'hC3, 8'hFF);
        push_pkt(3, model_ck(3));
        req   = 4'b1000;
        found = 0;
        for (int c = 0; c < 3000 && found == 0; c++) begin
            @(negedge clk);
            if (dbg_state == 3'(SEND_DATA) && rd_idx == 8'd5) found = 1;
        end
        chk("reach_send_data", 32'(found), 32'd1);
        @(posedge clk); #1;
        RESET = 1'b1;
        req   = 4'b0000;
        @(posedge clk); #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        chk("mid_rst_done", 32'(done), 32'd0);
        RESET = 1'b0;
        exp_q.delete();
        exp_done.delete();
        @(posedge clk); #1;
        chk("post_rst_tx_start", 32'(tx_start), 32'd0);
        chk("post_rst_state", 32'(dbg_state), 32'(IDLE));
        for (int c = 0; c < 200 && tx_busy; c++) @(posedge clk);
        #1;

        // fresh requests after reset: pointer restarts at requester 0
        mem[0][0] = 8'h11; mem[0][1] = 8'h22;
        setup_pkt(0, 8'h30, 8'h01);
        mem[3][0] = 8'h44;
        setup_pkt(3, 8'h33, 8'h00);
        push_pkt(0, 8'h9C);
        push_pkt(3, 8'h89);
        req = 4'b1001;
        wait_done(2, 1000);

        repeat (5) @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("exp_done_empty", 32'(exp_done.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
